tap_frame_decoder: RTL
======================

Name: tap_frame_decoder

Overview:
- JTAG USER-DR frame decoder in the TCK domain, successor to the single-word DR shifter.
- Deserialises a length-checked frame of {payload, channel} shifted in LSB first.
- Presents each accepted frame on a one-entry valid/ready output register.
- On capture, loads a status word that is shifted out on tdo, so the host can read frame count and overrun state.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- CHANNEL_WIDTH, 2, channel-id bits, carried in the frame LSBs.
- COUNT_WIDTH, 6, width of the accepted-frame counter; requires DATA_WIDTH+CHANNEL_WIDTH >= COUNT_WIDTH+2.

Ports:
- tck  in  1  TAP clock; all logic on rising edge.
- test_logic_reset_n  in  1  asynchronous, active-low reset.
- tdi  in  1  serial data in.
- ir_is_user  in  1  USER instruction selected; gates capture_dr, shift_dr and update_dr.
- capture_dr  in  1  TAP Capture-DR state.
- shift_dr  in  1  TAP Shift-DR state.
- update_dr  in  1  TAP Update-DR state.
- tdo  out  1  serial out, equal to shift-register bit 0.
- data  out  DATA_WIDTH  payload of the held frame.
- channel  out  CHANNEL_WIDTH  channel id of the held frame.
- valid  out  1  held frame present.
- ready  in  1  consumer accepts the frame when valid&&ready.
- length_error  out  1  one-cycle pulse: update with wrong bit count.
- overrun  out  1  sticky: accepted frame dropped because the holding register was full.
- frame_count  out  COUNT_WIDTH  frames loaded into the holding register, wrapping.

Behaviour:
- FW = CHANNEL_WIDTH+DATA_WIDTH (+1 with parity, see below).
- Reset (asynchronous) clears the shift register, bit counter, data, channel, valid, length_error, overrun and frame_count.
- Events below require ir_is_user=1; with ir_is_user=0 all TAP inputs are ignored.
- Priority when TAP inputs overlap: update_dr > capture_dr > shift_dr.
- capture_dr:
  - Shift register loads the status word, zero-padded: bit0=valid, bit1=overrun, bits[2+:COUNT_WIDTH]=frame_count.
  - Bit counter is cleared.
  - overrun is cleared (read-to-clear); the captured word still shows 1.
- shift_dr:
  - Shift register <= {tdi, sr[FW-1:1]}.
  - Bit counter increments, saturating at FW+1 ("too long").
  - Bits beyond FW push earlier bits out.
- update_dr, bit counter == FW (accept):
  - If valid==0 or (valid&&ready) this cycle: data<=sr[FW-1:CHANNEL_WIDTH], channel<=sr[CHANNEL_WIDTH-1:0], valid<=1, frame_count+=1 (wraps).
  - Otherwise: frame dropped, overrun<=1, frame_count unchanged.
- update_dr, bit counter != FW (reject): length_error=1 for the next cycle only, no load.
- Bit counter clears after every update_dr.
- Output handshake:
  - valid falls the cycle after valid&&ready, unless reloaded that same cycle.
  - data and channel stay stable while valid=1 and ready=0.
- Latency: valid rises on the first tck edge after update_dr is sampled.
- tdo is combinational from sr[0]; the host samples it on falling edge per TAP convention.
- Reset during a shift discards the partial frame; no error is flagged.

Optional Feature:
- Macro: TAP_FRAME_PARITY_EN.
- Defined:
  - FW gains one MSB odd-parity bit covering the payload and channel.
  - On a correct-length update, parity mismatch gives a one-cycle pulse on extra output parity_error and no load.
  - Status word bit gains no field.
- Undefined: no parity bit, no parity_error port; FW = CHANNEL_WIDTH+DATA_WIDTH.

Decomposition:
- Package tap_frame_pkg:
  - Status bit positions STATUS_VALID_BIT=0, STATUS_OVERRUN_BIT=1, STATUS_COUNT_LSB=2.
  - Function frame_width(data_w, chan_w, parity).
  - Function for counter width clog2(FW+2).
- Sub-module tap_frame_holding: one-entry valid/ready register with load, drop and overrun detection.
- Shift register, bit counter and status capture remain in the top level.

Test Plan:
- Reset, then shift 10 bits of 0x2D6 (DATA_WIDTH=8, CHANNEL_WIDTH=2) and update with ready=1 -> one cycle later valid=1, channel=2, data=0xB5, frame_count=1; valid drops the next cycle.
- Shift 9 bits then update; then shift 11 bits then update -> length_error pulses once each, valid stays 0, frame_count=0.
- ready=0: two valid frames A then B -> data holds A, overrun=1, frame_count=1. Then capture and shift 10 bits -> tdo yields 1,1,1,0,0,0,0,0,0,0; after capture overrun=0.
- valid=1 with ready=1 in the same cycle as update of a new frame -> new frame loaded, no overrun, frame_count increments.
- test_logic_reset_n pulsed low mid-shift, then full frame -> only the second frame accepted; all outputs 0 during reset.
- TAP_FRAME_PARITY_EN: 11-bit frame with correct odd parity -> accepted; flipped parity bit -> parity_error pulse, no valid.

Source files
------------

// File: rtl/tap_frame_pkg.sv
// Shared constants and width helpers for the JTAG USER-DR frame decoder.
// Defining TAP_FRAME_PARITY_EN appends an odd-parity MSB to every frame.
package tap_frame_pkg;

    localparam int STATUS_VALID_BIT   = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int STATUS_COUNT_LSB   = 2;

`ifdef TAP_FRAME_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic int frame_width(input int data_w, input int chan_w, input bit parity);
        return data_w + chan_w + (parity ? 1 : 0);
    endfunction

    // Counter must reach FW+1 so over-long frames stay distinguishable.
    function automatic int bit_count_width(input int fw);
        return $clog2(fw + 2);
    endfunction

endpackage

// File: rtl/tap_frame_holding.sv
// One-entry valid/ready holding register for decoded frames, with drop
// detection (sticky overrun) and a wrapping count of loaded frames.
module tap_frame_holding
    import tap_frame_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_WIDTH = 2,
    parameter int COUNT_WIDTH   = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load,
    input  logic [DATA_WIDTH-1:0]    i_data,
    input  logic [CHANNEL_WIDTH-1:0] i_channel,
    input  logic                     i_ready,
    input  logic                     i_clr_overrun,
    output logic                     o_valid,
    output logic [DATA_WIDTH-1:0]    o_data,
    output logic [CHANNEL_WIDTH-1:0] o_channel,
    output logic                     o_overrun,
    output logic [COUNT_WIDTH-1:0]   o_frame_count
);

    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [CHANNEL_WIDTH-1:0] r_channel;
    logic                     r_overrun;
    logic [COUNT_WIDTH-1:0]   r_frame_count;
    logic                     w_free;

    // The slot can take a new frame if empty or being drained this very cycle.
    assign w_free = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_data        <= '0;
            r_channel     <= '0;
            r_overrun     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (i_load && w_free) begin
                r_data        <= i_data;
                r_channel     <= i_channel;
                r_valid       <= 1'b1;
                r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end

            if (i_load && !w_free) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_valid       = r_valid;
    assign o_data        = r_data;
    assign o_channel     = r_channel;
    assign o_overrun     = r_overrun;
    assign o_frame_count = r_frame_count;

endmodule

// File: rtl/tap_frame_decoder.sv
// JTAG USER-DR frame decoder: shifts {payload, channel} in LSB first, length-checks
// it on Update-DR and captures a status word for tdo. Option: TAP_FRAME_PARITY_EN.
module tap_frame_decoder
    import tap_frame_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int CHANNEL_WIDTH = 2,
    parameter int COUNT_WIDTH   = 6
) (
    input  logic                     tck,
    input  logic                     test_logic_reset_n,
    input  logic                     tdi,
    input  logic                     ir_is_user,
    input  logic                     capture_dr,
    input  logic                     shift_dr,
    input  logic                     update_dr,
    output logic                     tdo,
    output logic [DATA_WIDTH-1:0]    data,
    output logic [CHANNEL_WIDTH-1:0] channel,
    output logic                     valid,
    input  logic                     ready,
    output logic                     length_error,
    output logic                     overrun,
    output logic [COUNT_WIDTH-1:0]   frame_count
`ifdef TAP_FRAME_PARITY_EN
    ,
    output logic                     parity_error
`endif
);

    localparam int PW  = DATA_WIDTH + CHANNEL_WIDTH;
    localparam int FW  = frame_width(DATA_WIDTH, CHANNEL_WIDTH, PARITY_EN);
    localparam int BCW = bit_count_width(FW);

    logic [FW-1:0]  r_sr;
    logic [BCW-1:0] r_bit_cnt;
    logic           r_length_error;
    logic [FW-1:0]  w_status;
    logic           w_upd;
    logic           w_cap;
    logic           w_shift;
    logic           w_len_ok;
    logic           w_par_ok;
    logic           w_accept;

    // Update wins over capture, capture over shift.
    assign w_upd    = ir_is_user && update_dr;
    assign w_cap    = ir_is_user && capture_dr && !update_dr;
    assign w_shift  = ir_is_user && shift_dr && !update_dr && !capture_dr;
    assign w_len_ok = (r_bit_cnt == BCW'(FW));
    assign w_accept = w_upd && w_len_ok && w_par_ok;

`ifdef TAP_FRAME_PARITY_EN
    logic r_parity_error;

    assign w_par_ok = ^r_sr;

    always_ff @(posedge tck or negedge test_logic_reset_n) begin
        if (!test_logic_reset_n) begin
            r_parity_error <= 1'b0;
        end else begin
            r_parity_error <= w_upd && w_len_ok && !w_par_ok;
        end
    end

    assign parity_error = r_parity_error;
`else
    assign w_par_ok = 1'b1;
`endif

    always_comb begin
        w_status                                   = '0;
        w_status[STATUS_VALID_BIT]                 = valid;
        w_status[STATUS_OVERRUN_BIT]               = overrun;
        w_status[STATUS_COUNT_LSB +: COUNT_WIDTH]  = frame_count;
    end

    always_ff @(posedge tck or negedge test_logic_reset_n) begin
        if (!test_logic_reset_n) begin
            r_sr           <= '0;
            r_bit_cnt      <= '0;
            r_length_error <= 1'b0;
        end else begin
            r_length_error <= w_upd && !w_len_ok;
            if (w_upd) begin
                r_bit_cnt <= '0;
            end else if (w_cap) begin
                r_sr      <= w_status;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_sr <= {tdi, r_sr[FW-1:1]};
                if (r_bit_cnt != BCW'(FW + 1)) begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    tap_frame_holding #(
        .DATA_WIDTH    (DATA_WIDTH),
        .CHANNEL_WIDTH (CHANNEL_WIDTH),
        .COUNT_WIDTH   (COUNT_WIDTH)
    ) u_holding (
        .clk           (tck),
        .rst_n         (test_logic_reset_n),
        .i_load        (w_accept),
        .i_data        (r_sr[PW-1:CHANNEL_WIDTH]),
        .i_channel     (r_sr[CHANNEL_WIDTH-1:0]),
        .i_ready       (ready),
        .i_clr_overrun (w_cap),
        .o_valid       (valid),
        .o_data        (data),
        .o_channel     (channel),
        .o_overrun     (overrun),
        .o_frame_count (frame_count)
    );

    assign tdo          = r_sr[0];
    assign length_error = r_length_error;

endmodule
